// File: rtl/audio_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// audio_pkg: shared I2S widths, slot constants and fetch FSM states
// Rev 1.0
// ------------------------------------------------------------------
package audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int SLOT_W     = 5;

  localparam logic [SLOT_W-1:0] LEFT_LOAD  = 5'd0;
  localparam logic [SLOT_W-1:0] RIGHT_LOAD = 5'd16;
  localparam logic [SLOT_W-1:0] LRCK_RISE  = 5'd15;
  localparam logic [SLOT_W-1:0] LRCK_FALL  = 5'd31;

  typedef enum logic [2:0] {
    FETCH_IDLE   = 3'd0,
    FETCH_REQ_L  = 3'd1,
    FETCH_WAIT_L = 3'd2,
    FETCH_REQ_R  = 3'd3,
    FETCH_WAIT_R = 3'd4,
    FETCH_FULL   = 3'd5
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ------------------------------------------------------------------
// i2s_clkgen: BCLK prescaler, slot counter and per-slot load strobes
// Rev 1.0
// ------------------------------------------------------------------
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  output logic              bclk_o,
  output logic              fall_o,
  output logic [SLOT_W-1:0] next_slot_o,
  output logic              load_l_o,
  output logic              load_r_o
);

  localparam int               PRE_W  = $clog2(BCLK_HALF_DIV);
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(BCLK_HALF_DIV - 1);

  logic [PRE_W-1:0]  presc_q;
  logic              bclk_q;
  logic [SLOT_W-1:0] slot_q;
  logic              presc_tc;

  assign presc_tc    = (presc_q == PRE_TC);
  // Strobes fire in the cycle before the edge that makes them true.
  assign fall_o      = enable_i & presc_tc & bclk_q;
  assign next_slot_o = slot_q + SLOT_W'(1);
  assign load_l_o    = fall_o & (next_slot_o == LEFT_LOAD);
  assign load_r_o    = fall_o & (next_slot_o == RIGHT_LOAD);
  assign bclk_o      = bclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= LRCK_FALL;
    end else if (!enable_i) begin
      presc_q <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= LRCK_FALL;
    end else if (presc_tc) begin
      presc_q <= '0;
      bclk_q  <= ~bclk_q;
      if (bclk_q) begin
        slot_q <= next_slot_o;
      end
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_stream_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// i2s_stream_tx: FIFO-fed stereo prefetch and Philips I2S serialiser
// Rev 1.0
// ------------------------------------------------------------------
module i2s_stream_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 18,
  parameter int READ_LATENCY  = 1,
  parameter int UNDERRUN_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  read_valid_i,
  input  logic [SAMPLE_W-1:0]   read_data_i,
  output logic                  read_en_o,
  output logic                  i2s_bclk_o,
  output logic                  i2s_lrck_o,
  output logic                  i2s_sdata_o,
  output logic                  frame_tick_o,
  output logic                  underrun_o,
  output logic [UNDERRUN_W-1:0] underrun_cnt_o
);

  localparam int               LAT_W  = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_TC = LAT_W'(READ_LATENCY);

  fetch_state_e          state_q;
  logic [LAT_W-1:0]      lat_q;
  logic                  read_en_q;
  logic [SAMPLE_W-1:0]   buf_l_q;
  logic [SAMPLE_W-1:0]   buf_r_q;
  logic [SAMPLE_W-1:0]   active_r_q;
  logic [SAMPLE_W-1:0]   shreg_q;
  logic                  lrck_q;
  logic                  frame_tick_q;
  logic                  underrun_q;
  logic [UNDERRUN_W-1:0] underrun_cnt_q;
  logic [UNDERRUN_W-1:0] underrun_cnt_d;
  logic                  lrck_d;

  logic              bclk_w;
  logic              fall_w;
  logic [SLOT_W-1:0] next_slot_w;
  logic              load_l_w;
  logic              load_r_w;

  i2s_clkgen #(
    .BCLK_HALF_DIV(BCLK_HALF_DIV)
  ) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .bclk_o     (bclk_w),
    .fall_o     (fall_w),
    .next_slot_o(next_slot_w),
    .load_l_o   (load_l_w),
    .load_r_o   (load_r_w)
  );

  assign underrun_cnt_d = (underrun_cnt_q == '1) ? underrun_cnt_q
                                                 : underrun_cnt_q + UNDERRUN_W'(1);
  assign lrck_d = (next_slot_w >= LRCK_RISE) && (next_slot_w != LRCK_FALL);

  // Fetch side: a capture in WAIT_R on the swap cycle lands after the
  // swap has already judged the buffer, so the pair waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_IDLE;
      lat_q     <= '0;
      read_en_q <= 1'b0;
      buf_l_q   <= '0;
      buf_r_q   <= '0;
    end else begin
      read_en_q <= 1'b0;
      case (state_q)
        FETCH_IDLE: state_q <= FETCH_REQ_L;
        FETCH_REQ_L, FETCH_REQ_R: begin
          if (read_valid_i) begin
            read_en_q <= 1'b1;
            lat_q     <= '0;
            state_q   <= (state_q == FETCH_REQ_L) ? FETCH_WAIT_L : FETCH_WAIT_R;
          end
        end
        FETCH_WAIT_L: begin
          if (lat_q == LAT_TC) begin
            buf_l_q <= read_data_i;
            state_q <= FETCH_REQ_R;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        FETCH_WAIT_R: begin
          if (lat_q == LAT_TC) begin
            buf_r_q <= read_data_i;
            state_q <= FETCH_FULL;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        FETCH_FULL: if (load_l_w) state_q <= FETCH_REQ_L;
        default:    state_q <= FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r_q     <= '0;
      shreg_q        <= '0;
      lrck_q         <= 1'b0;
      frame_tick_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      frame_tick_q <= load_l_w;
      if (!enable_i) begin
        shreg_q <= '0;
        lrck_q  <= 1'b0;
      end else if (fall_w) begin
        lrck_q <= lrck_d;
        if (load_l_w) begin
          if (state_q == FETCH_FULL) begin
            shreg_q    <= buf_l_q;
            active_r_q <= buf_r_q;
          end else begin
            shreg_q        <= '0;
            active_r_q     <= '0;
            underrun_q     <= 1'b1;
            underrun_cnt_q <= underrun_cnt_d;
          end
        end else if (load_r_w) begin
          shreg_q <= active_r_q;
        end else begin
          shreg_q <= {shreg_q[SAMPLE_W-2:0], 1'b0};
        end
      end
    end
  end

  assign read_en_o      = read_en_q;
  assign i2s_bclk_o     = bclk_w;
  assign i2s_lrck_o     = lrck_q;
  assign i2s_sdata_o    = shreg_q[SAMPLE_W-1];
  assign frame_tick_o   = frame_tick_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = underrun_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stream_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_i2s_stream_tx: FIFO model, I2S word decoder and directed scenarios
// Rev 1.0
// ------------------------------------------------------------------
module tb_i2s_stream_tx;

  localparam int HALF = 2;
  localparam int LAT  = 3;
  localparam int UW   = 3;

  typedef struct {
    logic        ch;
    logic [15:0] w;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_i;
  logic          read_valid_i = 1'b0;
  logic [15:0]   read_data_i  = 16'h0;
  logic          read_en_o;
  logic          i2s_bclk_o;
  logic          i2s_lrck_o;
  logic          i2s_sdata_o;
  logic          frame_tick_o;
  logic          underrun_o;
  logic [UW-1:0] underrun_cnt_o;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  logic [15:0] fifo_q[$];
  word_t       exp_q[$];
  word_t       obs_q[$];

  i2s_stream_tx #(
    .BCLK_HALF_DIV(HALF),
    .READ_LATENCY (LAT),
    .UNDERRUN_W   (UW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .read_valid_i  (read_valid_i),
    .read_data_i   (read_data_i),
    .read_en_o     (read_en_o),
    .i2s_bclk_o    (i2s_bclk_o),
    .i2s_lrck_o    (i2s_lrck_o),
    .i2s_sdata_o   (i2s_sdata_o),
    .frame_tick_o  (frame_tick_o),
    .underrun_o    (underrun_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  always #5 clk = ~clk;

  // FIFO model: a pop seen in cycle N presents its word only during
  // cycle N+LAT; every other cycle carries a deliberately wrong value.
  int          pend_cnt = 0;
  logic [15:0] pend_w   = 16'h0;
  logic        prev_ren = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pend_cnt    = 0;
      prev_ren    = 1'b0;
      read_data_i = 16'($urandom);
    end else begin
      read_data_i = ~pend_w;
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) read_data_i = pend_w;
      end
      if (read_en_o) begin
        checks++;
        assert (read_valid_i === 1'b1 && !prev_ren && fifo_q.size() > 0)
        else begin
          errors++;
          $error("FAIL read_en_protocol observed valid=%0b prev_en=%0b depth=%0d required valid=1 prev_en=0",
                 read_valid_i, prev_ren, fifo_q.size());
        end
        if (fifo_q.size() > 0) begin
          pend_w   = fifo_q.pop_front();
          pend_cnt = LAT;
          pops++;
        end
      end
      prev_ren     = read_en_o;
      read_valid_i = (fifo_q.size() > 0);
    end
  end

  // I2S decoder: a word is the 16 bits preceding each WS change,
  // sampled on BCLK rising edges; its channel is the WS before the change.
  logic        bclk_prev = 1'b0;
  logic        lrck_prev = 1'b0;
  logic [15:0] sh        = 16'h0;
  int          bitcnt    = 0;
  bit          first     = 1'b1;
  always @(negedge clk) begin
    if (rst || !enable_i) begin
      bitcnt    = 0;
      first     = 1'b1;
      lrck_prev = 1'b0;
    end else if (i2s_bclk_o && !bclk_prev) begin
      sh     = {sh[14:0], i2s_sdata_o};
      bitcnt = bitcnt + 1;
      if (i2s_lrck_o != lrck_prev) begin
        checks++;
        assert (bitcnt == (first ? 17 : 16))
        else begin
          errors++;
          $error("FAIL ws_period observed=%0d bits required=%0d", bitcnt, first ? 17 : 16);
        end
        obs_q.push_back('{ch: lrck_prev, w: sh});
        bitcnt = 0;
        first  = 1'b0;
      end
      lrck_prev = i2s_lrck_o;
    end
    bclk_prev = i2s_bclk_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick_o && n < 300);
    chk("frame_tick_seen", {31'd0, frame_tick_o}, 32'd1);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back('{ch: 1'b0, w: l});
    exp_q.push_back('{ch: 1'b1, w: r});
  endtask

  task automatic check_words();
    word_t o;
    word_t e;
    chk("word_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk("word_channel", {31'd0, o.ch}, {31'd0, e.ch});
      chk("word_value", {16'd0, o.w}, {16'd0, e.w});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    enable_i = 1'b0;
    fifo_q.delete();
    step(3);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          n_pairs;
    int          k;
    int          pops_before;
    logic [15:0] lw[$];
    logic [15:0] rw[$];
    logic [15:0] l1, r1, l2, r2;

    // Reset state, checked before any clock edge.
    rst      = 1'b1;
    enable_i = 1'b0;
    #2;
    chk("rst_read_en", {31'd0, read_en_o}, 32'd0);
    chk("rst_bclk_lrck_sdata", {29'd0, i2s_bclk_o, i2s_lrck_o, i2s_sdata_o}, 32'd0);
    chk("rst_tick_underrun", {30'd0, frame_tick_o, underrun_o}, 32'd0);
    chk("rst_underrun_cnt", {29'd0, underrun_cnt_o}, 32'd0);
    step(3);
    rst = 1'b0;

    // Prefetch one known frame, then play it plus a random run of frames.
    fifo_q.push_back(16'hA5C3);
    fifo_q.push_back(16'h0F0F);
    step(30);
    chk("prefetch_pops", pops, 2);
    enable_i = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_tick_o && k < 20);
    #1;
    chk("first_tick_latency", k, 4);
    chk("first_tick_underrun", {31'd0, underrun_o}, 32'd0);
    push_frame(16'hA5C3, 16'h0F0F);
    n_pairs = $urandom_range(2, 5);
    for (int i = 0; i < n_pairs; i++) begin
      lw.push_back(16'($urandom));
      rw.push_back(16'($urandom));
      fifo_q.push_back(lw[i]);
      fifo_q.push_back(rw[i]);
    end
    for (int f = 2; f <= n_pairs + 1; f++) begin
      wait_tick();
      chk("stream_underrun", {31'd0, underrun_o}, 32'd0);
      chk("stream_underrun_cnt", {29'd0, underrun_cnt_o}, 32'd0);
    end
    for (int i = 0; i < n_pairs - 1; i++) push_frame(lw[i], rw[i]);
    exp_q.push_back('{ch: 1'b0, w: lw[n_pairs-1]});

    // Asynchronous reset in the right-channel half of the last real frame.
    step(80);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_read_en", {31'd0, read_en_o}, 32'd0);
    chk("midrst_bclk_lrck_sdata", {29'd0, i2s_bclk_o, i2s_lrck_o, i2s_sdata_o}, 32'd0);
    chk("midrst_underrun", {28'd0, underrun_o, underrun_cnt_o}, 32'd0);
    enable_i = 1'b0;
    fifo_q.delete();
    check_words();
    chk("stream_pops", pops, 2 + 2 * n_pairs);
    step(3);
    rst = 1'b0;

    // Only a left word available: first frame is silent, left is kept.
    l1 = 16'($urandom);
    r1 = 16'($urandom);
    l2 = 16'($urandom);
    r2 = 16'($urandom);
    fifo_q.push_back(l1);
    step(30);
    chk("post_reset_pops", pops, 3 + 2 * n_pairs);
    enable_i = 1'b1;
    wait_tick();
    chk("partial_underrun", {31'd0, underrun_o}, 32'd1);
    chk("partial_cnt_1", {29'd0, underrun_cnt_o}, 32'd1);
    fifo_q.push_back(r1);
    fifo_q.push_back(l2);
    fifo_q.push_back(r2);
    wait_tick();
    chk("partial_cnt_2", {29'd0, underrun_cnt_o}, 32'd1);
    wait_tick();
    chk("partial_cnt_3", {29'd0, underrun_cnt_o}, 32'd1);
    wait_tick();
    chk("partial_cnt_4", {29'd0, underrun_cnt_o}, 32'd2);
    push_frame(16'h0, 16'h0);
    push_frame(l1, r1);
    push_frame(l2, r2);
    step(2);
    enable_i = 1'b0;
    step(2);
    check_words();

    // Empty FIFO: every frame silent, counter saturates at all-ones.
    do_reset();
    pops_before = pops;
    enable_i    = 1'b1;
    for (int f = 1; f <= 10; f++) begin
      wait_tick();
      chk("empty_underrun", {31'd0, underrun_o}, 32'd1);
      chk("empty_underrun_cnt", {29'd0, underrun_cnt_o}, (f < 7) ? f : 7);
      if (f < 10) push_frame(16'h0, 16'h0);
    end
    chk("empty_no_pops", pops, pops_before);
    step(2);
    enable_i = 1'b0;
    step(2);
    check_words();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
